// File: rtl/cbd_poly_streamer_if.sv
// Beat bus from the polynomial streamer into the NTT coefficient memory.
// The streamer drives the master side; the memory writer is the slave.
interface cbd_poly_streamer_if #(
  parameter int unsigned LANES = 2,
  parameter int unsigned TAG_W = 3
);
  localparam int unsigned AW = 8 - $clog2(LANES);

  logic                  beat_valid_o;
  logic                  beat_ready_i;
  logic [LANES*12-1:0]   beat_data_o;
  logic [AW-1:0]         beat_addr_o;
  logic [TAG_W-1:0]      beat_tag_o;
  logic                  beat_last_o;

  modport master (
    output beat_valid_o, beat_data_o, beat_addr_o, beat_tag_o, beat_last_o,
    input  beat_ready_i
  );

  modport slave (
    input  beat_valid_o, beat_data_o, beat_addr_o, beat_tag_o, beat_last_o,
    output beat_ready_i
  );
endinterface

// File: rtl/cbd_poly_streamer.sv
// Two-slot polynomial buffer between the CBD sampler and NTT coefficient memory:
// captures whole 256x12 polynomials and streams them as LANES-wide beats.
module cbd_poly_streamer #(
  parameter int unsigned LANES = 2,
  parameter int unsigned TAG_W = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   load_i,
  input  logic [255:0][11:0]     poly_i,
  input  logic [TAG_W-1:0]       tag_i,
  output logic                   load_ready_o,
  cbd_poly_streamer_if.master    beat_if,
  output logic                   idle_o,
  output logic                   err_ovf_o,
  output logic                   err_range_o
);
  localparam int unsigned LW = $clog2(LANES);
  localparam int unsigned AW = 8 - LW;
  localparam int unsigned DW = LANES * 12;

  typedef enum logic {S_IDLE, S_STREAM} state_e;

  state_e                    state_q, state_d;
  logic [1:0][255:0][11:0]   slot_q;
  logic [1:0][TAG_W-1:0]     slot_tag_q;
  logic [1:0]                full_q, full_d;
  logic                      wr_sel_q, wr_sel_d;
  logic                      rd_sel_q, rd_sel_d;
  logic [1:0]                occ_q, occ_d;
  logic [AW-1:0]             k_q, k_d;
  logic [DW-1:0]             data_q, data_d;
  logic [TAG_W-1:0]          otag_q, otag_d;
  logic                      last_q, last_d;
  logic                      ovf_q, ovf_d;
  logic                      rng_q, rng_d;

  logic                      load_acc, hs, done, byp, range_bad;
  logic [255:0][11:0]        src;
  logic [7:0]                base;

  always_comb begin
    load_acc  = load_i && (occ_q != 2'd2);
    hs        = (state_q == S_STREAM) && beat_if.beat_ready_i;
    done      = hs && last_q;

    range_bad = 1'b0;
    for (int unsigned i = 0; i < 256; i++) begin
      if (poly_i[i] >= 12'd3329) range_bad = 1'b1;
    end

    full_d = full_q;
    if (load_acc) full_d[wr_sel_q] = 1'b1;
    if (done)     full_d[rd_sel_q] = 1'b0;

    wr_sel_d = wr_sel_q ^ load_acc;
    rd_sel_d = rd_sel_q ^ done;

    occ_d = occ_q;
    if (load_acc && !done)      occ_d = occ_q + 2'd1;
    else if (!load_acc && done) occ_d = occ_q - 2'd1;

    k_d = hs ? k_q + AW'(1) : k_q;

    state_d = state_q;
    case (state_q)
      S_IDLE:   if (full_d[rd_sel_q]) state_d = S_STREAM;
      S_STREAM: if (done && !full_d[rd_sel_d]) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // A slot being written this edge is also the next one to stream when the
    // buffer was empty; feed the output stage straight from poly_i then.
    byp  = load_acc && (wr_sel_q == rd_sel_d);
    src  = byp ? poly_i : slot_q[rd_sel_d];
    base = 8'(k_d) << LW;

    data_d = data_q;
    otag_d = otag_q;
    last_d = last_q;
    if (state_d == S_STREAM) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        data_d[l*12 +: 12] = src[base + 8'(l)];
      end
      otag_d = byp ? tag_i : slot_tag_q[rd_sel_d];
      last_d = (k_d == '1);
    end

    ovf_d = ovf_q | (load_i && !load_acc);
    rng_d = rng_q | (load_acc && range_bad);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      occ_q    <= '0;
      k_q      <= '0;
      data_q   <= '0;
      otag_q   <= '0;
      last_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rng_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      occ_q    <= occ_d;
      k_q      <= k_d;
      data_q   <= data_d;
      otag_q   <= otag_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
      rng_q    <= rng_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_acc) begin
      slot_q[wr_sel_q]     <= poly_i;
      slot_tag_q[wr_sel_q] <= tag_i;
    end
  end

  assign load_ready_o         = (occ_q != 2'd2);
  assign idle_o               = (full_q == 2'b00) && (state_q == S_IDLE);
  assign err_ovf_o            = ovf_q;
  assign err_range_o          = rng_q;
  assign beat_if.beat_valid_o = (state_q == S_STREAM);
  assign beat_if.beat_data_o  = data_q;
  assign beat_if.beat_addr_o  = k_q;
  assign beat_if.beat_tag_o   = otag_q;
  assign beat_if.beat_last_o  = last_q;
endmodule

// File: tb/tb_cbd_poly_streamer.sv
// Directed bench for cbd_poly_streamer at LANES=2: single, back-to-back,
// backpressure, overflow, range and mid-stream reset scenarios.
module tb_cbd_poly_streamer;
  localparam int unsigned LANES = 2;
  localparam int unsigned TAG_W = 3;

  typedef logic [255:0][11:0] poly_t;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             load  = 1'b0;
  poly_t            poly  = '0;
  logic [TAG_W-1:0] tag   = '0;
  logic             load_ready, idle, err_ovf, err_range;

  int n_vec = 0;
  int n_err = 0;

  poly_t            exp_p [4];
  logic [TAG_W-1:0] exp_t [4];

  cbd_poly_streamer_if #(.LANES(LANES), .TAG_W(TAG_W)) bif ();

  cbd_poly_streamer #(.LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .load_i       (load),
    .poly_i       (poly),
    .tag_i        (tag),
    .load_ready_o (load_ready),
    .beat_if      (bif.master),
    .idle_o       (idle),
    .err_ovf_o    (err_ovf),
    .err_range_o  (err_range)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic poly_t ramp(input bit rev);
    poly_t p;
    for (int i = 0; i < 256; i++) p[i] = rev ? 12'(255 - i) : 12'(i);
    return p;
  endfunction

  task automatic check_reset_state(input string name);
    check_eq({name, "_valid"},  32'(bif.beat_valid_o), 32'd0);
    check_eq({name, "_lready"}, 32'(load_ready), 32'd1);
    check_eq({name, "_idle"},   32'(idle), 32'd1);
    check_eq({name, "_ovf"},    32'(err_ovf), 32'd0);
    check_eq({name, "_range"},  32'(err_range), 32'd0);
    check_eq({name, "_data"},   32'(bif.beat_data_o), 32'd0);
    check_eq({name, "_addr"},   32'(bif.beat_addr_o), 32'd0);
    check_eq({name, "_tag"},    32'(bif.beat_tag_o), 32'd0);
    check_eq({name, "_last"},   32'(bif.beat_last_o), 32'd0);
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    load  = 1'b0;
    bif.beat_ready_i = 1'b0;
    tick();
    tick();
    check_reset_state(name);
    rst_n = 1'b1;
  endtask

  task automatic load_poly(input poly_t p, input logic [TAG_W-1:0] t);
    load = 1'b1;
    poly = p;
    tag  = t;
    tick();
    load = 1'b0;
  endtask

  // Consume n polynomials from exp_p/exp_t, first one starting at beat k0.
  task automatic drain(input int n, input int k0, input bit bp, input bit chk_lr);
    int idx = 0;
    int k   = k0;
    int cyc = 0;
    bit rdy;
    bit stalled = 0;
    logic [23:0] hd;
    logic [6:0]  ha;
    logic [2:0]  ht;
    while (idx < n && cyc < 4000) begin
      if (stalled) begin
        check_eq($sformatf("hold_data k%0d", k), 32'(bif.beat_data_o), 32'(hd));
        check_eq($sformatf("hold_addr k%0d", k), 32'(bif.beat_addr_o), 32'(ha));
        check_eq($sformatf("hold_tag k%0d", k),  32'(bif.beat_tag_o), 32'(ht));
      end
      if (!bp) check_eq($sformatf("gapless p%0d k%0d", idx, k), 32'(bif.beat_valid_o), 32'd1);
      if (chk_lr) check_eq($sformatf("lready p%0d k%0d", idx, k), 32'(load_ready), 32'(idx != 0));
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bif.beat_ready_i = rdy;
      if (bif.beat_valid_o && rdy) begin
        check_eq($sformatf("data p%0d k%0d", idx, k), 32'(bif.beat_data_o),
                 32'({exp_p[idx][2*k+1], exp_p[idx][2*k]}));
        check_eq($sformatf("addr p%0d k%0d", idx, k), 32'(bif.beat_addr_o), 32'(k));
        check_eq($sformatf("tag p%0d k%0d", idx, k),  32'(bif.beat_tag_o), 32'(exp_t[idx]));
        check_eq($sformatf("last p%0d k%0d", idx, k), 32'(bif.beat_last_o), 32'(k == 127));
        stalled = 0;
        k++;
        if (k == 128) begin
          k = 0;
          idx++;
        end
      end else begin
        stalled = bif.beat_valid_o;
        hd = bif.beat_data_o;
        ha = bif.beat_addr_o;
        ht = bif.beat_tag_o;
      end
      tick();
      cyc++;
    end
    bif.beat_ready_i = 1'b0;
    check_eq("drain_count", 32'(idx), 32'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    poly_t p;
    bif.beat_ready_i = 1'b0;

    // Single polynomial, consumer always ready
    do_reset("rst0");
    bif.beat_ready_i = 1'b1;
    exp_p[0] = ramp(0);
    exp_t[0] = 3'd5;
    load_poly(exp_p[0], 3'd5);
    drain(1, 0, 0, 0);
    check_eq("single_idle",  32'(idle), 32'd1);
    check_eq("single_valid", 32'(bif.beat_valid_o), 32'd0);

    // Back-to-back A then B
    do_reset("rst1");
    bif.beat_ready_i = 1'b1;
    exp_p[0] = ramp(0); exp_t[0] = 3'd0;
    exp_p[1] = ramp(1); exp_t[1] = 3'd1;
    load_poly(exp_p[0], 3'd0);
    check_eq("b2b_first_valid",  32'(bif.beat_valid_o), 32'd1);
    check_eq("b2b_first_data",   32'(bif.beat_data_o), 32'h001000);
    check_eq("b2b_first_addr",   32'(bif.beat_addr_o), 32'd0);
    check_eq("b2b_lready_after_a", 32'(load_ready), 32'd1);
    load_poly(exp_p[1], 3'd1);
    drain(2, 1, 0, 1);
    check_eq("b2b_idle", 32'(idle), 32'd1);

    // Backpressure
    do_reset("rst2");
    exp_p[0] = ramp(0); exp_t[0] = 3'd5;
    load_poly(exp_p[0], 3'd5);
    drain(1, 0, 1, 0);
    check_eq("bp_idle", 32'(idle), 32'd1);

    // Overflow: third load while both slots occupied
    do_reset("rst3");
    exp_p[0] = ramp(0); exp_t[0] = 3'd2;
    exp_p[1] = ramp(1); exp_t[1] = 3'd3;
    for (int i = 0; i < 256; i++) p[i] = 12'h123;
    load_poly(exp_p[0], 3'd2);
    check_eq("ovf_after_a", 32'(err_ovf), 32'd0);
    load_poly(exp_p[1], 3'd3);
    check_eq("ovf_after_b", 32'(err_ovf), 32'd0);
    check_eq("ovf_lready_full", 32'(load_ready), 32'd0);
    load_poly(p, 3'd4);
    check_eq("ovf_after_c", 32'(err_ovf), 32'd1);
    drain(2, 0, 0, 0);
    bif.beat_ready_i = 1'b1;
    tick();
    tick();
    check_eq("ovf_no_c_valid", 32'(bif.beat_valid_o), 32'd0);
    check_eq("ovf_no_c_idle",  32'(idle), 32'd1);
    check_eq("ovf_sticky",     32'(err_ovf), 32'd1);
    bif.beat_ready_i = 1'b0;

    // Range: 3328 is legal, 3329 flags but passes through
    do_reset("rst4");
    for (int i = 0; i < 256; i++) p[i] = 12'd3328;
    exp_p[0] = p; exp_t[0] = 3'd1;
    load_poly(p, 3'd1);
    check_eq("range_3328", 32'(err_range), 32'd0);
    drain(1, 0, 0, 0);
    p = ramp(0);
    p[17] = 12'd3329;
    exp_p[0] = p; exp_t[0] = 3'd6;
    load_poly(p, 3'd6);
    check_eq("range_3329", 32'(err_range), 32'd1);
    drain(1, 0, 0, 0);
    check_eq("range_sticky", 32'(err_range), 32'd1);

    // Reset in the middle of streaming A with B queued and an overflow pending
    do_reset("rst5");
    bif.beat_ready_i = 1'b1;
    load_poly(ramp(0), 3'd0);
    load_poly(ramp(1), 3'd1);
    load_poly(ramp(0), 3'd2);
    check_eq("mid_ovf_set", 32'(err_ovf), 32'd1);
    for (int i = 0; i < 200 && bif.beat_addr_o != 7'd40; i++) tick();
    check_eq("mid_at_beat40", 32'(bif.beat_addr_o), 32'd40);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_state("mid_rst");
    exp_p[0] = ramp(1); exp_t[0] = 3'd7;
    bif.beat_ready_i = 1'b1;
    load_poly(exp_p[0], 3'd7);
    drain(1, 0, 0, 0);
    check_eq("mid_final_idle", 32'(idle), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cbd_poly_streamer.md
# cbd_poly_streamer

Double-buffered polynomial streamer that sits directly downstream of the CBD sampler. It captures one complete 256-coefficient polynomial (`poly_t`, 12-bit coefficients in [0, 3328]) per load pulse. It then emits the coefficients as LANES-wide beats with a BRAM word address and a polynomial tag over a valid/ready handshake into the NTT coefficient memory. Two slots let the sampler deliver the next polynomial while the current one is still draining.

## Interface
Parameters:
- `LANES`, default 2: coefficients per beat; power of two, 1..8.
- `TAG_W`, default 3: width of the polynomial index tag (covers 2*ML_KEM_K polynomials).

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_n_i` in 1: synchronous active-low reset.
- `load_i` in 1: capture `poly_i`/`tag_i` into a free slot this cycle.
- `poly_i` in `poly_t` (256×12): polynomial; coefficient i at `poly_i[i]`.
- `tag_i` in TAG_W: polynomial index carried with the data.
- `load_ready_o` out 1: at least one slot is free.
- `beat_valid_o` out 1: beat outputs are valid.
- `beat_ready_i` in 1: consumer accepts the beat.
- `beat_data_o` out LANES*12: coefficients LANES*k .. LANES*k+LANES-1, lane 0 in the LSBs.
- `beat_addr_o` out 8-log2(LANES): beat index k.
- `beat_tag_o` out TAG_W: tag of the polynomial being streamed.
- `beat_last_o` out 1: beat k = 256/LANES-1.
- `idle_o` out 1: both slots empty and no beat pending.
- `err_ovf_o` out 1: sticky; a load was dropped.
- `err_range_o` out 1: sticky; a loaded coefficient was ≥ 3329.

## Operation
- Storage: two slots, each holding 256×12 data, a tag and a full bit. The write pointer `wr_sel` and read pointer `rd_sel` each toggle per use. A 2-bit `occ` counter holds 0..2.
- Load: when `load_i && load_ready_o`, write `poly_i` and `tag_i` into slot `wr_sel`, set its full bit, toggle `wr_sel`, and increment `occ`.
- Dropped load: when `load_i && !load_ready_o`, the load is dropped, slot contents are untouched, and `err_ovf_o` is set.
- `load_ready_o = (occ != 2)`. It is decoded from registered state only and has no combinational path from `beat_ready_i`.
- Range check: on an accepted load, if any `poly_i[i] ≥ 3329`, set `err_range_o`. The data is still stored and streamed unmodified.
- Stream FSM has two states:
  - IDLE: `beat_valid_o = 0`. Go to STREAM when the `rd_sel` slot is full, with k = 0.
  - STREAM: `beat_valid_o = 1`. On a handshake (`beat_valid_o && beat_ready_i`), k increments.
  - On a handshake with `beat_last_o`: clear the slot, toggle `rd_sel`, decrement `occ`, and reset k to 0.
  - After that last-beat handshake, stay in STREAM if the other slot is full (no bubble); otherwise go to IDLE.
- Simultaneous accepted load and last-beat handshake in one cycle: both take effect and `occ` is unchanged.
- Beat outputs are driven from a registered output stage. They are held stable while `beat_valid_o && !beat_ready_i`.
- Width rules:
  - k is a counter of 8-log2(LANES) bits that wraps to 0 after the last beat.
  - `occ` never exceeds 2 and never underflows.
- Reset at any time (including mid-stream) returns the block to the reset state. Slot contents are don't-care.

## Timing
- Reset values: `load_ready_o = 1`, `idle_o = 1`; all other outputs 0, including `beat_data_o`, `beat_addr_o`, `beat_tag_o` and both error flags.
- Load-to-first-beat latency: `load_i` accepted at edge t (block empty) gives `beat_valid_o = 1` with k = 0 in the cycle after t.
- Throughput: with `beat_ready_i` held at 1, one beat per cycle. 256/LANES beats per polynomial (128 at LANES = 2). Back-to-back polynomials have zero idle cycles.
- `load_ready_o` rises in the cycle after the last-beat handshake that frees a slot.
- Error flags are asserted one cycle after the offending `load_i` edge and stay set until reset.

## Test plan
- **Single polynomial:** reset, load `poly[i] = i` with `tag = 5`, `beat_ready_i = 1`.
  - Required: 128 beats on consecutive cycles starting at t+1.
  - Beat k: `data = {2k+1, 2k}`, `addr = k`, `tag = 5`; `last` only at k = 127.
  - Then `idle_o = 1`.
- **Back-to-back:** load A (`poly[i] = i`, `tag = 0`), then B (`poly[i] = 255-i`, `tag = 1`) in the next cycle, ready = 1.
  - Required: 256 gapless beats, A then B.
  - `load_ready_o = 0` from after B's load until the cycle after A's last beat.
- **Backpressure:** ready toggles pseudo-randomly at 50%.
  - Required: data, addr and tag are stable on every stalled cycle.
  - The accepted beat sequence is identical to the single-polynomial case.
- **Overflow:** ready = 0, loads A, B, C on three consecutive cycles.
  - Required: C is dropped and `err_ovf_o = 1`.
  - Releasing ready streams only A and B.
- **Range:** load with `poly[17] = 3329`.
  - Required: `err_range_o = 1` the next cycle.
  - Beat 8 carries 3329 in lane 1 unmodified.
- **Reset mid-stream:** `rst_n_i = 0` for one cycle at beat 40 of A while B is also loaded.
  - Required: the next cycle shows `beat_valid_o = 0`, `load_ready_o = 1`, `idle_o = 1` and both errors at 0.
  - A new load streams from k = 0.
